// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths and FSM encoding for the data-memory arbiter
package dmem_arbiter_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LANE_W = 4;
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports and memory-side signals of the arbiter
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;
  logic req0, req1, lock0, lock1, gnt0, gnt1, ack0, ack1;
  logic [ADDR_W-1:0] addr0, addr1, mem_a;
  logic [DATA_W-1:0] wd0, wd1, rdata0, rdata1, mem_wd, mem_rd;
  logic [LANE_W-1:0] we0, we1, mem_we;
  modport slave (
    input  req0, req1, lock0, lock1, addr0, addr1, wd0, wd1, we0, we1, mem_rd,
    output gnt0, gnt1, ack0, ack1, rdata0, rdata1, mem_a, mem_wd, mem_we
  );
  modport master (
    output req0, req1, lock0, lock1, addr0, addr1, wd0, wd1, we0, we1, mem_rd,
    input  gnt0, gnt1, ack0, ack1, rdata0, rdata1, mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; on a tie the side that did not win last goes
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with bus lock and lock timeout in front of the data memory
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 15
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  state_t state, state_n;
  logic last, last_n;
  logic [7:0] lock_cnt, lock_cnt_n;
  logic [1:0] pick, gnt, ack;
  logic [DATA_W-1:0] rdata0, rdata1;
  rr_pick2 u_pick (.req({bus.req1, bus.req0}), .last(last), .gnt(pick));
  always_comb begin
    state_n = state;
    last_n = last;
    lock_cnt_n = lock_cnt;
    gnt = 2'b00;
    case (state)
      ST_IDLE: begin
        gnt = pick;
        last_n = (pick != 2'b00) ? pick[1] : last;
        state_n = (pick[0] && bus.lock0) ? ST_LOCK0 : (pick[1] && bus.lock1) ? ST_LOCK1 : ST_IDLE;
        lock_cnt_n = (state_n != ST_IDLE) ? 8'd1 : lock_cnt;
      end
      ST_LOCK0: begin
        gnt = {1'b0, bus.req0};
        lock_cnt_n = (lock_cnt == 8'(MAX_LOCK)) ? lock_cnt : lock_cnt + 8'd1;
        if (!bus.lock0 || lock_cnt == 8'(MAX_LOCK)) begin
          state_n = ST_IDLE;
          last_n = 1'b0;
        end
      end
      ST_LOCK1: begin
        gnt = {bus.req1, 1'b0};
        lock_cnt_n = (lock_cnt == 8'(MAX_LOCK)) ? lock_cnt : lock_cnt + 8'd1;
        if (!bus.lock1 || lock_cnt == 8'(MAX_LOCK)) begin
          state_n = ST_IDLE;
          last_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      last <= 1'b1;
      lock_cnt <= 8'd0;
      ack <= 2'b00;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= state_n;
      last <= last_n;
      lock_cnt <= lock_cnt_n;
      ack <= gnt;
      if (gnt[0] && bus.we0 == '0) rdata0 <= bus.mem_rd;
      if (gnt[1] && bus.we1 == '0) rdata1 <= bus.mem_rd;
    end
  end
  // Idle memory still sees requester 0's address so mem_a never floats
  assign bus.mem_a = gnt[1] ? bus.addr1 : bus.addr0;
  assign bus.mem_wd = gnt[1] ? bus.wd1 : bus.wd0;
  assign bus.mem_we = gnt[1] ? bus.we1 : gnt[0] ? bus.we0 : '0;
  assign bus.gnt0 = gnt[0];
  assign bus.gnt1 = gnt[1];
  assign bus.ack0 = ack[0];
  assign bus.ack1 = ack[1];
  assign bus.rdata0 = rdata0;
  assign bus.rdata1 = rdata1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with an ownership-level reference model checked every cycle
module tb_dmem_arbiter;
  localparam int MAX_LOCK = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic preload = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] mem [0:255];
  dmem_arbiter_if bus();
  dmem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 5) ? 32'hDEADBEEF : {b, b, b, b};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk)
    if (preload) for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    else for (int l = 0; l < 4; l++)
      if (bus.mem_we[l]) mem[bus.mem_a[7:0]][8*l +: 8] <= bus.mem_wd[8*l +: 8];
  assign bus.mem_rd = mem[bus.mem_a[7:0]];

  // Reference model: who owns the bus, how long, and who won last
  int owner = -1;
  int held = 0;
  int last_w = 1;
  logic e_ack0 = 1'b0, e_ack1 = 1'b0;
  logic [31:0] e_rd0 = '0, e_rd1 = '0;
  logic [31:0] mref [0:255];
  always @(negedge clk) begin
    int g, a;
    logic [1:0] r, lk;
    logic [3:0] we_g;
    logic [31:0] wd_g;
    r = {bus.req1, bus.req0};
    lk = {bus.lock1, bus.lock0};
    if (owner >= 0) g = r[owner] ? owner : -1;
    else if (r == 2'b11) g = 1 - last_w;
    else g = r[0] ? 0 : r[1] ? 1 : -1;
    a = (g == 1) ? int'(bus.addr1[7:0]) : int'(bus.addr0[7:0]);
    we_g = (g == 1) ? bus.we1 : (g == 0) ? bus.we0 : 4'h0;
    wd_g = (g == 1) ? bus.wd1 : bus.wd0;
    chk("m_gnt0", bus.gnt0, g == 0);
    chk("m_gnt1", bus.gnt1, g == 1);
    chk("m_mem_a", bus.mem_a, (g == 1) ? bus.addr1 : bus.addr0);
    chk("m_mem_wd", bus.mem_wd, wd_g);
    chk("m_mem_we", bus.mem_we, we_g);
    chk("m_ack0", bus.ack0, e_ack0);
    chk("m_ack1", bus.ack1, e_ack1);
    chk("m_rdata0", bus.rdata0, e_rd0);
    chk("m_rdata1", bus.rdata1, e_rd1);
    if (preload) for (int i = 0; i < 256; i++) mref[i] = init_word(i);
    else if (g >= 0) begin
      if (we_g == 4'h0) begin
        if (g == 0) e_rd0 = mref[a];
        else e_rd1 = mref[a];
      end else for (int l = 0; l < 4; l++)
        if (we_g[l]) mref[a][8*l +: 8] = wd_g[8*l +: 8];
    end
    e_ack0 = !reset && g == 0;
    e_ack1 = !reset && g == 1;
    if (reset) begin
      owner = -1;
      held = 0;
      last_w = 1;
      e_rd0 = '0;
      e_rd1 = '0;
    end else if (owner >= 0) begin
      if (!lk[owner] || held == MAX_LOCK) begin
        last_w = owner;
        owner = -1;
      end else held++;
    end else if (g >= 0) begin
      last_w = g;
      if (lk[g]) begin
        owner = g;
        held = 1;
      end
    end
  end

  initial begin
    logic [5:0] seq;
    {bus.req0, bus.req1, bus.lock0, bus.lock1} = 4'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wd0 = '0; bus.wd1 = '0; bus.we0 = '0; bus.we1 = '0;
    tick();
    tick();
    preload = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ack0", bus.ack0, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
    tick();
    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 16'd0; bus.addr1 = 16'd1;
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seq[i] = bus.gnt0;
      chk("tie_one_hot", bus.gnt0 ^ bus.gnt1, 1);
      tick();
    end
    chk("tie_seq", seq, 6'b010101);
    bus.req1 = 0; bus.addr0 = 16'd5;
    @(negedge clk);
    chk("rd_gnt0", bus.gnt0, 1);
    tick();
    bus.req0 = 0; bus.req1 = 1; bus.addr1 = 16'd5; bus.we1 = 4'b0101; bus.wd1 = 32'h11223344;
    @(negedge clk);
    chk("rd_ack0", bus.ack0, 1);
    chk("rd_data", bus.rdata0, 32'hDEADBEEF);
    chk("wr_gnt1", bus.gnt1, 1);
    tick();
    bus.req1 = 0; bus.we1 = '0; bus.req0 = 1;
    @(negedge clk);
    chk("wr_ack1", bus.ack1, 1);
    chk("wr_rdata1_kept", bus.rdata1, 32'h01010101);
    tick();
    bus.req0 = 0; bus.req1 = 1; bus.addr1 = 16'd1;
    @(negedge clk);
    chk("raw_data", bus.rdata0, 32'hDE22BE44);
    tick();
    bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 16'd3; bus.addr1 = 16'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lock_gnt0", bus.gnt0, 1);
      chk("lock_gnt1_low", bus.gnt1, 0);
      tick();
    end
    bus.lock0 = 0;
    @(negedge clk);
    chk("unlock_last_gnt0", bus.gnt0, 1);
    tick();
    @(negedge clk);
    chk("unlock_gnt1", bus.gnt1, 1);
    tick();
    bus.lock0 = 1;
    @(negedge clk);
    chk("to_c1_gnt0", bus.gnt0, 1);
    tick();
    bus.req0 = 0; bus.we0 = 4'hF; bus.wd0 = 32'hCAFEF00D;
    @(negedge clk);
    chk("to_idle_gnt", {bus.gnt1, bus.gnt0}, 0);
    chk("to_idle_we", bus.mem_we, 0);
    tick();
    bus.req0 = 1; bus.we0 = '0;
    @(negedge clk);
    chk("to_c3_gnt0", bus.gnt0, 1);
    tick();
    @(negedge clk);
    chk("to_c4_gnt0", bus.gnt0, 1);
    tick();
    @(negedge clk);
    chk("timeout_gnt1", bus.gnt1, 1);
    tick();
    {bus.req0, bus.req1, bus.lock0} = 3'b0;
    tick();
    bus.req0 = 1; bus.addr0 = 16'd5; reset = 1;
    @(negedge clk);
    chk("rst_mid_gnt0", bus.gnt0, 1);
    tick();
    reset = 0; bus.req1 = 1;
    @(negedge clk);
    chk("rst_mid_ack0", bus.ack0, 0);
    chk("rst_mid_rdata0", bus.rdata0, 0);
    chk("post_rst_tie", bus.gnt0, 1);
    tick();
    {bus.req0, bus.req1} = 2'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
